// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing FSM: per-state datapath selects, memory handshake,
// ALU control decode and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       alucontrol,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t state_q;
  state_t state_d;
  logic   retire;
  logic   mem_req_raw;
  logic   memwrite_raw;
  logic   irwrite_raw;
  logic   pcen_raw;
  logic   regwrite_raw;
  logic   illegal_raw;

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcen_raw     = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    pcsrc        = 2'b00;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcen_raw    = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:       state_d = ADDIEXEC;
          OP_J:          state_d = JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      MEMWR: begin
        mem_req_raw  = 1'b1;
        memwrite_raw = 1'b1;
        iord         = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        // bne inverts the sense of the zero flag
        pcen_raw   = zero ^ (op == OP_BNE);
        state_d    = FETCH;
        retire     = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      JUMP: begin
        pcsrc    = 2'b10;
        pcen_raw = 1'b1;
        state_d  = FETCH;
        retire   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write enables and requests are held off for as long as reset is low
  assign mem_req  = mem_req_raw  & reset;
  assign memwrite = memwrite_raw & reset;
  assign irwrite  = irwrite_raw  & reset;
  assign pcen     = pcen_raw     & reset;
  assign regwrite = regwrite_raw & reset;
  assign illegal  = illegal_raw  & reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus
// hand-written reset, wrap and memory-stall sequences.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05, ADDI = 6'h08, JMP = 6'h02, BAD = 6'h3f;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, memwrite, iord, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [3:0] alucontrol, state;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic mreq, mw, iord, irw, pcen;
    logic [1:0] pcsrc;
    logic asa;
    logic [1:0] asb;
    logic [3:0] aluc;
    logic rdst, m2r, rw, ill;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic [5:0] op, funct;
    logic zero, rdy;
    obs_t exp;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                   input logic [3:0] st, input logic mreq, input logic mw, input logic io,
                   input logic irw, input logic pe, input logic [1:0] ps, input logic asa,
                   input logic [1:0] asb, input logic [3:0] aluc, input logic rd,
                   input logic m2r, input logic rw, input logic ill, input logic [3:0] cnt);
    vec_t e;
    e.op = o; e.funct = f; e.zero = z; e.rdy = r;
    e.exp = '{st, mreq, mw, io, irw, pe, ps, asa, asb, aluc, rd, m2r, rw, ill, cnt};
    tbl.push_back(e);
  endtask

  function automatic obs_t sample();
    sample = '{state, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, 4'(instr_count)};
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %p required %p", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // Runs one instruction opcode from FETCH with mem_ready high
  task automatic run_instr(input logic [5:0] o, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      op = o; mem_ready = 1'b1;
    end
  endtask

  initial begin
    // lw, ready throughout
    v(LW,0,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 0);
    v(LW,0,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 0);
    v(LW,0,0,1, 2, 0,0,0,0,0, 0,1,2,4'h2, 0,0,0,0, 0);
    v(LW,0,0,1, 3, 1,0,1,0,0, 0,0,0,4'h2, 0,0,0,0, 0);
    v(LW,0,0,1, 4, 0,0,0,0,0, 0,0,0,4'h2, 0,1,1,0, 0);
    // sw with a one-cycle fetch stall and three MEMWR wait cycles
    v(SW,0,0,0, 0, 1,0,0,0,0, 0,0,1,4'h2, 0,0,0,0, 1);
    v(SW,0,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 1);
    v(SW,0,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 1);
    v(SW,0,0,1, 2, 0,0,0,0,0, 0,1,2,4'h2, 0,0,0,0, 1);
    v(SW,0,0,0, 5, 1,1,1,0,0, 0,0,0,4'h2, 0,0,0,0, 1);
    v(SW,0,0,0, 5, 1,1,1,0,0, 0,0,0,4'h2, 0,0,0,0, 1);
    v(SW,0,0,0, 5, 1,1,1,0,0, 0,0,0,4'h2, 0,0,0,0, 1);
    v(SW,0,0,1, 5, 1,1,1,0,0, 0,0,0,4'h2, 0,0,0,0, 1);
    // R-type slt; mem_ready low in EXECUTE must not stall
    v(RT,6'h2a,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 2);
    v(RT,6'h2a,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 2);
    v(RT,6'h2a,0,0, 6, 0,0,0,0,0, 0,1,0,4'h7, 0,0,0,0, 2);
    v(RT,6'h2a,0,1, 7, 0,0,0,0,0, 0,0,0,4'h2, 1,0,1,0, 2);
    // R-type unknown funct
    v(RT,6'h3f,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 3);
    v(RT,6'h3f,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 3);
    v(RT,6'h3f,0,1, 6, 0,0,0,0,0, 0,1,0,4'h2, 0,0,0,0, 3);
    v(RT,6'h3f,0,1, 7, 0,0,0,0,0, 0,0,0,4'h2, 1,0,1,0, 3);
    // bne zero=0 taken, bne zero=1 not taken, beq zero=1 taken
    v(BNE,0,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 4);
    v(BNE,0,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 4);
    v(BNE,0,0,1, 8, 0,0,0,0,1, 1,1,0,4'h6, 0,0,0,0, 4);
    v(BNE,0,1,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 5);
    v(BNE,0,1,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 5);
    v(BNE,0,1,1, 8, 0,0,0,0,0, 1,1,0,4'h6, 0,0,0,0, 5);
    v(BEQ,0,1,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 6);
    v(BEQ,0,1,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 6);
    v(BEQ,0,1,1, 8, 0,0,0,0,1, 1,1,0,4'h6, 0,0,0,0, 6);
    // addi
    v(ADDI,0,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 7);
    v(ADDI,0,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 7);
    v(ADDI,0,0,1, 9, 0,0,0,0,0, 0,1,2,4'h2, 0,0,0,0, 7);
    v(ADDI,0,0,1,10, 0,0,0,0,0, 0,0,0,4'h2, 0,0,1,0, 7);
    // j
    v(JMP,0,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 8);
    v(JMP,0,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,0, 8);
    v(JMP,0,0,1,11, 0,0,0,0,1, 2,0,0,4'h2, 0,0,0,0, 8);
    // illegal opcode: pulse in DECODE, back to FETCH, not counted
    v(BAD,0,0,1, 0, 1,0,0,1,1, 0,0,1,4'h2, 0,0,0,0, 9);
    v(BAD,0,0,1, 1, 0,0,0,0,0, 0,0,3,4'h2, 0,0,0,1, 9);
    v(BAD,0,0,0, 0, 1,0,0,0,0, 0,0,1,4'h2, 0,0,0,0, 9);

    // Reset held: FETCH selects, all enables low, counter cleared
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_obs("reset_state", sample(), '{4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0, 1'b0, 2'd1,
                                         4'h2, 1'b0,1'b0,1'b0,1'b0, 4'd0});
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
      #1;
      check_obs($sformatf("row%0d", i), sample(), tbl[i].exp);
    end

    // FSM is now in FETCH with count 9; seven jumps wrap the 4-bit count to 0
    for (int k = 0; k < 7; k++) run_instr(JMP, 3);
    @(negedge clk);
    op = JMP; mem_ready = 1'b0;
    #1;
    check_bit("wrap_state", state, 4'd0);
    check_bit("wrap_count", 4'(instr_count), 4'd0);

    // One jump (count 1), then sw stalled in MEMWR and reset mid-access
    run_instr(JMP, 3);
    @(negedge clk);
    op = SW; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_bit("pre_reset_state", state, 4'd5);
    check_bit("pre_reset_memwrite", {3'b0, memwrite}, 4'd1);
    check_bit("pre_reset_count", 4'(instr_count), 4'd1);
    reset = 1'b0;
    #1;
    check_bit("rst_state", state, 4'd0);
    check_bit("rst_memwrite", {3'b0, memwrite}, 4'd0);
    check_bit("rst_mem_req", {3'b0, mem_req}, 4'd0);
    check_bit("rst_count", 4'(instr_count), 4'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_bit("post_rst_state", state, 4'd0);
    check_bit("post_rst_mem_req", {3'b0, mem_req}, 4'd1);
    @(negedge clk);
    #1;
    check_bit("post_rst_hold", state, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
